// File: rtl/mips_muldiv_if.sv
// Core-to-HI/LO-unit bus: instruction operands in, architectural HI/LO and handshake out.
interface mips_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             op_valid;
    logic [2:0]       op_code;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             mf_req;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall;

    modport master (
        output op_valid, op_code, op_a, op_b, mf_req,
        input  hi, lo, busy, done, stall
    );

    modport slave (
        input  op_valid, op_code, op_a, op_b, mf_req,
        output hi, lo, busy, done, stall
    );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide engine owning HI/LO; retires BITS_PER_CYCLE bits per cycle
// and stalls the core while a result is pending.
module mips_muldiv_unit #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clock_enable,
    mips_muldiv_if.slave  bus
);
    localparam int ITER_N = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W  = (ITER_N > 1) ? $clog2(ITER_N) : 1;
    localparam int PW     = 2 * WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] work_hi_r, work_lo_r, mcand_r, a_raw_r;
    logic             sign_r, dsign_r, dz_r, is_div_r;
    logic [WIDTH-1:0] hi_r, lo_r;
    logic             busy_r, done_r;

    logic             accept_s, start_s, is_signed_s, is_div_s, a_neg_s, b_neg_s;
    logic [WIDTH-1:0] abs_a_s, abs_b_s;
    logic [WIDTH-1:0] iter_hi_s, iter_lo_s, diff_s;
    logic [WIDTH:0]   sum_s;
    logic             ge_s;
    logic [PW-1:0]    prod_neg_s;
    logic [WIDTH-1:0] fix_hi_s, fix_lo_s;

    assign accept_s    = bus.op_valid & (state_r == ST_IDLE) & clock_enable & (bus.op_code <= 3'd5);
    assign start_s     = accept_s & (bus.op_code <= 3'd3);
    assign is_signed_s = (bus.op_code == 3'd0) | (bus.op_code == 3'd2);
    assign is_div_s    = (bus.op_code == 3'd2) | (bus.op_code == 3'd3);
    assign a_neg_s     = is_signed_s & bus.op_a[WIDTH-1];
    assign b_neg_s     = is_signed_s & bus.op_b[WIDTH-1];
    assign abs_a_s     = a_neg_s ? (~bus.op_a + WIDTH'(1)) : bus.op_a;
    assign abs_b_s     = b_neg_s ? (~bus.op_b + WIDTH'(1)) : bus.op_b;

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else if (clock_enable) begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: if (start_s) state_s = ST_ITER; else state_s = ST_IDLE;
            ST_ITER: if (cnt_r == '0) state_s = ST_FIX; else state_s = ST_ITER;
            ST_FIX:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // One iteration: BITS_PER_CYCLE shift-add (multiply) or restoring-subtract (divide) steps
    always_comb begin
        iter_hi_s = work_hi_r;
        iter_lo_s = work_lo_r;
        sum_s     = '0;
        diff_s    = '0;
        ge_s      = 1'b0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (is_div_r) begin
                ge_s   = ({1'b0, iter_hi_s, iter_lo_s[WIDTH-1]} >= {2'b00, mcand_r});
                diff_s = {iter_hi_s[WIDTH-2:0], iter_lo_s[WIDTH-1]} - mcand_r;
                if (ge_s) iter_hi_s = diff_s;
                else      iter_hi_s = {iter_hi_s[WIDTH-2:0], iter_lo_s[WIDTH-1]};
                iter_lo_s = {iter_lo_s[WIDTH-2:0], ge_s};
            end else begin
                sum_s     = {1'b0, iter_hi_s} + (iter_lo_s[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
                iter_lo_s = {sum_s[0], iter_lo_s[WIDTH-1:1]};
                iter_hi_s = sum_s[WIDTH:1];
            end
        end
    end

    // Sign correction of the unsigned result; divide-by-zero returns the raw dividend in HI
    always_comb begin
        fix_hi_s   = work_hi_r;
        fix_lo_s   = work_lo_r;
        prod_neg_s = ~{work_hi_r, work_lo_r} + PW'(1);
        if (!is_div_r) begin
            if (sign_r) {fix_hi_s, fix_lo_s} = prod_neg_s;
            else        {fix_hi_s, fix_lo_s} = {work_hi_r, work_lo_r};
        end else if (dz_r) begin
            fix_hi_s = a_raw_r;
            fix_lo_s = work_lo_r;
        end else begin
            fix_lo_s = sign_r  ? (~work_lo_r + WIDTH'(1)) : work_lo_r;
            fix_hi_s = dsign_r ? (~work_hi_r + WIDTH'(1)) : work_hi_r;
        end
    end

    // Datapath, counter, HI/LO and handshake registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r     <= '0;
            work_hi_r <= '0;
            work_lo_r <= '0;
            mcand_r   <= '0;
            a_raw_r   <= '0;
            sign_r    <= 1'b0;
            dsign_r   <= 1'b0;
            dz_r      <= 1'b0;
            is_div_r  <= 1'b0;
            hi_r      <= '0;
            lo_r      <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else if (clock_enable) begin
            busy_r <= (state_s != ST_IDLE);
            done_r <= (state_r == ST_FIX);
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        cnt_r     <= CNT_W'(ITER_N - 1);
                        work_hi_r <= '0;
                        work_lo_r <= is_div_s ? abs_a_s : abs_b_s;
                        mcand_r   <= is_div_s ? abs_b_s : abs_a_s;
                        a_raw_r   <= bus.op_a;
                        sign_r    <= a_neg_s ^ b_neg_s;
                        dsign_r   <= a_neg_s;
                        dz_r      <= is_div_s & (bus.op_b == '0);
                        is_div_r  <= is_div_s;
                    end else if (accept_s && bus.op_code == 3'd4) begin
                        hi_r <= bus.op_a;
                    end else if (accept_s && bus.op_code == 3'd5) begin
                        lo_r <= bus.op_a;
                    end
                end
                ST_ITER: begin
                    work_hi_r <= iter_hi_s;
                    work_lo_r <= iter_lo_s;
                    if (cnt_r != '0) cnt_r <= cnt_r - CNT_W'(1);
                end
                ST_FIX: begin
                    hi_r <= fix_hi_s;
                    lo_r <= fix_lo_s;
                end
                default: ;
            endcase
        end
    end

    assign bus.hi    = hi_r;
    assign bus.lo    = lo_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.stall = busy_r & (bus.op_valid | bus.mf_req);
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed testbench for mips_muldiv_unit: one instance at 1 bit/cycle, one at 4 bits/cycle.
module tb_mips_muldiv_unit;
    logic clk;
    logic reset;
    logic clock_enable;
    logic clock_enable4;
    int   errors = 0;
    int   checks = 0;
    int   bc;

    mips_muldiv_if #(.WIDTH(32)) bus1 ();
    mips_muldiv_if #(.WIDTH(32)) bus4 ();

    mips_muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .reset(reset), .clock_enable(clock_enable), .bus(bus1));
    mips_muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .reset(reset), .clock_enable(clock_enable4), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue1(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
        bus1.op_valid = 1'b1;
        bus1.op_code  = code;
        bus1.op_a     = a;
        bus1.op_b     = b;
        step();
        bus1.op_valid = 1'b0;
    endtask

    task automatic wait1(output int cycles);
        cycles = 0;
        while (bus1.busy === 1'b1 && cycles < 300) begin
            cycles++;
            step();
        end
    endtask

    task automatic run1(input string tag, input logic [2:0] code, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        issue1(code, a, b);
        wait1(n);
        check({tag, "_busy_cycles"}, 64'(n), 64'd33);
        check({tag, "_done"}, 64'(bus1.done), 64'd1);
        check({tag, "_hi"}, 64'(bus1.hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(bus1.lo), 64'(exp_lo));
        step();
        check({tag, "_done_drop"}, 64'(bus1.done), 64'd0);
    endtask

    initial begin
        reset = 1'b1; clock_enable = 1'b1; clock_enable4 = 1'b1;
        bus1.op_valid = 1'b0; bus1.op_code = 3'd0; bus1.op_a = 32'd0; bus1.op_b = 32'd0; bus1.mf_req = 1'b0;
        bus4.op_valid = 1'b0; bus4.op_code = 3'd0; bus4.op_a = 32'd0; bus4.op_b = 32'd0; bus4.mf_req = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("rst_hi", 64'(bus1.hi), 64'd0);
        check("rst_lo", 64'(bus1.lo), 64'd0);
        check("rst_busy", 64'(bus1.busy), 64'd0);
        check("rst_done", 64'(bus1.done), 64'd0);
        repeat (2) step();
        reset = 1'b1;
        step();

        // MULTU max*max, with HI/LO untouched mid-operation
        issue1(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (10) step();
        check("t1_hi_mid", 64'(bus1.hi), 64'd0);
        check("t1_busy_mid", 64'(bus1.busy), 64'd1);
        wait1(bc);
        check("t1_busy_cycles", 64'(bc), 64'd23);
        check("t1_done", 64'(bus1.done), 64'd1);
        check("t1_hi", 64'(bus1.hi), 64'hFFFFFFFE);
        check("t1_lo", 64'(bus1.lo), 64'h00000001);
        step();
        check("t1_done_drop", 64'(bus1.done), 64'd0);

        run1("mult_neg3x7", 3'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run1("mult_minxmin", 3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        run1("div_m7_2", 3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run1("divu_7_0", 3'd3, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF);
        run1("div_m7_0", 3'd2, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
        run1("div_min_m1", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run1("divu_100_7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);

        // Ignored op_code and MF in IDLE
        bus1.op_valid = 1'b1; bus1.op_code = 3'd6; bus1.op_a = 32'h55; bus1.op_b = 32'h3;
        bus1.mf_req = 1'b1;
        #1;
        check("idle_stall", 64'(bus1.stall), 64'd0);
        step();
        bus1.op_valid = 1'b0; bus1.mf_req = 1'b0;
        check("op6_busy", 64'(bus1.busy), 64'd0);
        check("op6_hi", 64'(bus1.hi), 64'd2);
        check("op6_lo", 64'(bus1.lo), 64'd14);

        // Stall while busy; MULT held until the done cycle
        issue1(3'd3, 32'd100, 32'd7);
        repeat (4) step();
        bus1.mf_req = 1'b1;
        bus1.op_valid = 1'b1; bus1.op_code = 3'd0; bus1.op_a = 32'd3; bus1.op_b = 32'd5;
        #1;
        bc = 0;
        while (bus1.busy === 1'b1 && bc < 300) begin
            check("t4_stall_busy", 64'(bus1.stall), 64'd1);
            bc++;
            step();
        end
        check("t4_stall_done", 64'(bus1.stall), 64'd0);
        check("t4_done", 64'(bus1.done), 64'd1);
        check("t4_hi", 64'(bus1.hi), 64'd2);
        check("t4_lo", 64'(bus1.lo), 64'd14);
        step();
        bus1.op_valid = 1'b0; bus1.mf_req = 1'b0;
        check("t4_mult_accepted", 64'(bus1.busy), 64'd1);
        wait1(bc);
        check("t4_mult_hi", 64'(bus1.hi), 64'd0);
        check("t4_mult_lo", 64'(bus1.lo), 64'd15);

        // MTHI then async reset mid-DIV
        issue1(3'd4, 32'h00001234, 32'd0);
        check("mthi_hi", 64'(bus1.hi), 64'h1234);
        check("mthi_busy", 64'(bus1.busy), 64'd0);
        issue1(3'd2, 32'd1000, 32'd3);
        repeat (9) step();
        check("t5_busy_before_rst", 64'(bus1.busy), 64'd1);
        reset = 1'b0;
        #1;
        check("t5_rst_busy", 64'(bus1.busy), 64'd0);
        check("t5_rst_done", 64'(bus1.done), 64'd0);
        check("t5_rst_hi", 64'(bus1.hi), 64'd0);
        check("t5_rst_lo", 64'(bus1.lo), 64'd0);
        step();
        reset = 1'b1;
        step();

        // clock_enable low for 5 cycles mid-MULT
        issue1(3'd0, 32'hFFFFFFFE, 32'h40000001);
        bc = 0;
        repeat (3) begin bc++; step(); end
        clock_enable = 1'b0;
        repeat (5) begin
            check("t5_ce_busy_hold", 64'(bus1.busy), 64'd1);
            bc++;
            step();
        end
        clock_enable = 1'b1;
        while (bus1.busy === 1'b1 && bc < 300) begin
            bc++;
            step();
        end
        check("t5_ce_busy_cycles", 64'(bc), 64'd38);
        check("t5_ce_done", 64'(bus1.done), 64'd1);
        check("t5_ce_hi", 64'(bus1.hi), 64'hFFFFFFFF);
        check("t5_ce_lo", 64'(bus1.lo), 64'h7FFFFFFE);

        // Four bits per cycle
        bus4.op_valid = 1'b1; bus4.op_code = 3'd1; bus4.op_a = 32'h12345678; bus4.op_b = 32'h9ABCDEF0;
        step();
        bus4.op_valid = 1'b0;
        bc = 0;
        while (bus4.busy === 1'b1 && bc < 300) begin
            bc++;
            step();
        end
        check("t6_busy_cycles", 64'(bc), 64'd9);
        check("t6_done", 64'(bus4.done), 64'd1);
        check("t6_hi", 64'(bus4.hi), 64'h0B00EA4E);
        check("t6_lo", 64'(bus4.lo), 64'h242D2080);
        bus4.op_valid = 1'b1; bus4.op_code = 3'd4; bus4.op_a = 32'hCAFEF00D;
        step();
        bus4.op_valid = 1'b0;
        check("t6_mthi_hi", 64'(bus4.hi), 64'hCAFEF00D);
        check("t6_mthi_busy", 64'(bus4.busy), 64'd0);
        check("t6_mthi_lo", 64'(bus4.lo), 64'h242D2080);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
